i2s_transmitter_8ch: RTL

- FPGA-side serializer feeding an 8-channel DAC slot.
- Takes a stream of sample words, channel-ordered 0..7, from an upstream FIFO handshake.
- Drives a shared bck/lrck pair plus four I2S data lines, each carrying one stereo pair.
- Sits directly upstream of the slot's data pins. The slot's I2S receivers consume its output.

---
 rtl/i2s_transmitter_8ch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/i2s_transmitter_8ch.sv
// -----------------------------------------------------------------------------
// i2s_transmitter_8ch
//
// Serializes an 8-channel sample stream onto four I2S data lines that share
// one bit clock (bck) and one word clock (lrck). Words arrive channel-ordered
// 0..7 over a ready/enable handshake, are collected in a staging buffer, and
// are moved as a complete set into the frame buffer at each frame boundary.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   run        transmitter enable; low clears all state on the next edge
//   in_data    sample word (sample_width bits)
//   in_enable  upstream has a valid word
//   in_ready   block accepts a word (transfer on in_enable && in_ready)
//   bck        bit clock, bck_div clk cycles per period
//   lrck       word clock, 0 = left half, 1 = right half
//   sdata[k]   channel 2k in the left half, channel 2k+1 in the right half
//   underrun   one-clk pulse when a frame boundary finds < 8 staged words
// -----------------------------------------------------------------------------
module i2s_transmitter_8ch #(
    parameter int sample_width = 24,
    parameter int slot_width   = 32,
    parameter int bck_div      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic [sample_width-1:0] in_data,
    input  logic                    in_enable,
    output logic                    in_ready,
    output logic                    bck,
    output logic                    lrck,
    output logic [3:0]              sdata,
    output logic                    underrun
);

    localparam int DIV_W = $clog2(bck_div);
    localparam int BIT_W = $clog2(2 * slot_width);
    localparam int IDX_W = $clog2(sample_width);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bck_div - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(bck_div / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * slot_width - 1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(slot_width);
    localparam logic [BIT_W-1:0] SAMP     = BIT_W'(sample_width);
    localparam logic [3:0]       FULL     = 4'd8;

    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [3:0]              count;
    logic [sample_width-1:0] stage [8];
    logic [sample_width-1:0] frame [8];

    logic [DIV_W-1:0] div_nxt;
    logic [BIT_W-1:0] bit_nxt;
    logic [BIT_W-1:0] pos_nxt;
    logic [BIT_W-1:0] diff_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic             half_nxt;
    logic             data_bit;
    logic             fall;
    logic             boundary;
    logic             accept;
    logic [3:0]       count_nxt;
    logic [3:0]       sdata_nxt;

    // Everything for the next fall event is derived from the advanced
    // bit counter, so lrck and sdata move together with the bck fall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        div_nxt   = '0;
        bit_nxt   = '0;
        sdata_nxt = '0;
        count_nxt = count;

        fall     = (div_cnt == DIV_LAST);
        boundary = fall && (bit_cnt == BIT_LAST);
        accept   = in_enable && in_ready;

        if (!fall) div_nxt = div_cnt + 1'b1;
        if (bit_cnt != BIT_LAST) bit_nxt = bit_cnt + 1'b1;

        half_nxt = (bit_nxt >= SLOT);
        pos_nxt  = half_nxt ? bit_nxt - SLOT : bit_nxt;
        // Position 0 of each slot is the I2S delay bit; positions past the
        // sample are padding. Both drive 0.
        data_bit = (pos_nxt != '0) && (pos_nxt <= SAMP);
        diff_nxt = SAMP - pos_nxt;
        bit_idx  = diff_nxt[IDX_W-1:0];

        for (int k = 0; k < 4; k++) begin
            if (data_bit) sdata_nxt[k] = frame[{2'(k), half_nxt}][bit_idx];
        end

        // A full buffer is emptied by the boundary load; in_ready is low at
        // count 8, so a load and an accept never coincide.
        if (boundary && (count == FULL)) count_nxt = '0;
        else if (accept)                 count_nxt = count + 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            count    <= '0;
            bck      <= 1'b0;
            lrck     <= 1'b0;
            sdata    <= '0;
            in_ready <= 1'b0;
            underrun <= 1'b0;
            for (int i = 0; i < 8; i++) frame[i] <= '0;
        end else if (!run) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            count    <= '0;
            bck      <= 1'b0;
            lrck     <= 1'b0;
            sdata    <= '0;
            in_ready <= 1'b0;
            underrun <= 1'b0;
            for (int i = 0; i < 8; i++) frame[i] <= '0;
        end else begin
            div_cnt  <= div_nxt;
            bck      <= (div_nxt >= DIV_HALF);
            count    <= count_nxt;
            in_ready <= (count_nxt < FULL);
            // A short buffer plays silence but keeps its words, so the next
            // complete set still starts at channel 0.
            underrun <= boundary && (count != FULL);
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= half_nxt;
                sdata   <= sdata_nxt;
            end
            if (boundary) begin
                for (int i = 0; i < 8; i++) begin
                    frame[i] <= (count == FULL) ? stage[i] : '0;
                end
            end
        end
    end

    // NOTE: the staging memory has no reset; count alone says which entries
    // are valid, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) stage[count[2:0]] <= in_data;
    end

endmodule
